// File: rtl/fc_operand_streamer_if.sv
// fc_operand_streamer_if: IFM/weight SRAM read ports and the accelerator operand
// stream. master = streamer side, slave = SRAMs plus accelerator side.
interface fc_operand_streamer_if #(
  parameter int IFM_WIDTH   = 8,
  parameter int WGT_WIDTH   = 8,
  parameter int TILING_SIZE = 8,
  parameter int IFM_AW      = 16,
  parameter int WGT_AW      = 23
);
  logic [IFM_AW-1:0]                ifm_addr;
  logic                             ifm_ren;
  logic [IFM_WIDTH-1:0]             ifm_rdata;
  logic [WGT_AW-1:0]                wgt_addr;
  logic                             wgt_ren;
  logic [TILING_SIZE*WGT_WIDTH-1:0] wgt_rdata;
  logic                             ifm_read;
  logic [IFM_WIDTH-1:0]             ifm;
  logic                             valid_ifm;
  logic                             wgt_read;
  logic [TILING_SIZE*WGT_WIDTH-1:0] wgt;
  logic                             wgt_valid;

  modport master (
    output ifm_addr, ifm_ren, wgt_addr, wgt_ren, ifm, valid_ifm, wgt, wgt_valid,
    input  ifm_rdata, wgt_rdata, ifm_read, wgt_read
  );

  modport slave (
    input  ifm_addr, ifm_ren, wgt_addr, wgt_ren, ifm, valid_ifm, wgt, wgt_valid,
    output ifm_rdata, wgt_rdata, ifm_read, wgt_read
  );
endinterface

// File: rtl/fc_operand_streamer.sv
// fc_operand_streamer: streams the IFM, then every weight tile, from the operand SRAMs
// to the FC accelerator. Define FC_STREAM_STALL_CNT_EN to build the stall cycle counter.
module fc_operand_streamer #(
  parameter int IFM_WIDTH   = 8,
  parameter int WGT_WIDTH   = 8,
  parameter int TILING_SIZE = 8,
  parameter int IFM_SIZE    = 9162,
  parameter int KERNEL_SIZE = 4096,
  parameter int IFM_AW      = 16,
  parameter int WGT_AW      = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           stall_cnt,
  fc_operand_streamer_if.master bus
);

  localparam int NUM_TILES = KERNEL_SIZE / TILING_SIZE;
  localparam int TILE_W    = $clog2(NUM_TILES + 1);
  localparam int WGT_W     = TILING_SIZE * WGT_WIDTH;
  localparam logic [IFM_AW-1:0] LAST_ELEM = IFM_AW'(IFM_SIZE - 1);
  localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);

  typedef enum logic [1:0] {S_IDLE, S_IFM, S_WGT, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [IFM_AW-1:0]   ifm_idx, ifm_addr_q, elem_idx;
  logic [TILE_W-1:0]   tile_idx;
  logic [WGT_AW-1:0]   wgt_lin, wgt_addr_q;
  logic                ifm_req, wgt_req, last_word, start_ok;
  logic                ifm_vld_q, wgt_vld_q;
  logic [IFM_WIDTH-1:0] ifm_hold_q;
  logic [WGT_W-1:0]    wgt_hold_q;

  assign last_word = (tile_idx == LAST_TILE) && (elem_idx == LAST_ELEM);
  assign start_ok  = (state == S_IDLE) && start;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    ifm_req   = 1'b0;
    wgt_req   = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_IFM;
      S_IFM: begin
        ifm_req = bus.ifm_read;
        if (ifm_req && ifm_idx == LAST_ELEM) state_nxt = S_WGT;
      end
      S_WGT: begin
        wgt_req = bus.wgt_read;
        if (wgt_req && last_word) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: registers use <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ifm_idx    <= '0;
      ifm_addr_q <= '0;
      elem_idx   <= '0;
      tile_idx   <= '0;
      wgt_lin    <= '0;
      wgt_addr_q <= '0;
      ifm_vld_q  <= 1'b0;
      wgt_vld_q  <= 1'b0;
      ifm_hold_q <= '0;
      wgt_hold_q <= '0;
    end else begin
      state     <= state_nxt;
      ifm_vld_q <= ifm_req;
      wgt_vld_q <= wgt_req;
      if (start_ok) begin
        ifm_idx  <= '0;
        elem_idx <= '0;
        tile_idx <= '0;
        wgt_lin  <= '0;
      end
      if (ifm_req) begin
        ifm_idx    <= ifm_idx + 1'b1;
        ifm_addr_q <= ifm_idx;
      end
      if (wgt_req) begin
        wgt_lin    <= wgt_lin + 1'b1;
        wgt_addr_q <= wgt_lin;
        if (elem_idx == LAST_ELEM) begin
          elem_idx <= '0;
          tile_idx <= tile_idx + 1'b1;
        end else begin
          elem_idx <= elem_idx + 1'b1;
        end
      end
      // The output holding registers keep the last presented operand once valid drops.
      if (ifm_vld_q) ifm_hold_q <= bus.ifm_rdata;
      if (wgt_vld_q) wgt_hold_q <= bus.wgt_rdata;
    end
  end

  // SRAM reads are issued in the request cycle so data lines up one cycle later.
  assign bus.ifm_ren   = ifm_req;
  assign bus.ifm_addr  = ifm_req ? ifm_idx : ifm_addr_q;
  assign bus.wgt_ren   = wgt_req;
  assign bus.wgt_addr  = wgt_req ? wgt_lin : wgt_addr_q;
  assign bus.valid_ifm = ifm_vld_q;
  assign bus.ifm       = ifm_vld_q ? bus.ifm_rdata : ifm_hold_q;
  assign bus.wgt_valid = wgt_vld_q;
  assign bus.wgt       = wgt_vld_q ? bus.wgt_rdata : wgt_hold_q;
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);

`ifdef FC_STREAM_STALL_CNT_EN
  logic [31:0] stall_q;
  logic        stall;

  assign stall = ((state == S_IFM) && !bus.ifm_read) || ((state == S_WGT) && !bus.wgt_read);

  always_ff @(posedge clk) begin
    if (rst || start_ok)            stall_q <= '0;
    else if (stall && stall_q != '1) stall_q <= stall_q + 1'b1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fc_operand_streamer.sv
// tb_fc_operand_streamer: scoreboard bench for fc_operand_streamer with IFM_SIZE=4,
// KERNEL_SIZE=16, TILING_SIZE=8; honours FC_STREAM_STALL_CNT_EN when defined.
module tb_fc_operand_streamer;
  localparam int IFM_SIZE    = 4;
  localparam int KERNEL_SIZE = 16;
  localparam int TILING_SIZE = 8;
  localparam int IFM_WIDTH   = 8;
  localparam int WGT_WIDTH   = 8;
  localparam int IFM_AW      = 16;
  localparam int WGT_AW      = 23;
  localparam int N_WORDS     = IFM_SIZE * (KERNEL_SIZE / TILING_SIZE);
  localparam int WW          = TILING_SIZE * WGT_WIDTH;
  localparam int S_IDLE = 0, S_IFM = 1, S_WGT = 2, S_DONE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [31:0] stall_cnt;

  fc_operand_streamer_if #(.IFM_WIDTH(IFM_WIDTH), .WGT_WIDTH(WGT_WIDTH),
    .TILING_SIZE(TILING_SIZE), .IFM_AW(IFM_AW), .WGT_AW(WGT_AW)) bus ();

  fc_operand_streamer #(.IFM_WIDTH(IFM_WIDTH), .WGT_WIDTH(WGT_WIDTH), .TILING_SIZE(TILING_SIZE),
    .IFM_SIZE(IFM_SIZE), .KERNEL_SIZE(KERNEL_SIZE), .IFM_AW(IFM_AW), .WGT_AW(WGT_AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .stall_cnt(stall_cnt), .bus(bus));

  always #5 clk = ~clk;

  logic [IFM_WIDTH-1:0] ifm_mem [IFM_SIZE];
  logic [WW-1:0]        wgt_mem [N_WORDS];

  // Synchronous-read SRAM models; out-of-range reads return a poison pattern.
  always @(posedge clk) begin
    if (bus.ifm_ren) bus.ifm_rdata <= (int'(bus.ifm_addr) < IFM_SIZE) ? ifm_mem[int'(bus.ifm_addr)] : 8'h5A;
    if (bus.wgt_ren) bus.wgt_rdata <= (int'(bus.wgt_addr) < N_WORDS) ? wgt_mem[int'(bus.wgt_addr)] : {TILING_SIZE{8'h5A}};
  end

  int n_vec = 0, n_err = 0;
  int m_state = S_IDLE, m_ifm_idx = 0, m_wgt_lin = 0, m_iaddr = 0, m_waddr = 0, m_stall = 0;
  int cur_state = S_IDLE, cur_stall = 0;
  logic exp_ifm_v = 1'b0, exp_wgt_v = 1'b0;
  logic [IFM_WIDTH-1:0] last_ifm = '0;
  logic [WW-1:0]        last_wgt = '0;
  logic [IFM_WIDTH-1:0] ifm_q [$];
  logic [WW-1:0]        wgt_q [$];

  function automatic logic [31:0] exp_stall();
`ifdef FC_STREAM_STALL_CNT_EN
    return 32'(cur_stall);
`else
    return 32'd0;
`endif
  endfunction

  // One clock cycle: score the registered stream outputs, apply inputs, advance the model.
  task automatic drive(input logic st, input logic ir, input logic wr, input logic r);
    logic [IFM_WIDTH-1:0] ei;
    logic [WW-1:0]        ew;
    @(negedge clk);
    n_vec++;
    if (bus.valid_ifm !== exp_ifm_v) begin n_err++; $display("FAIL sb_valid_ifm got %b want %b t=%0t", bus.valid_ifm, exp_ifm_v, $time); end
    if (bus.valid_ifm === 1'b1) begin
      n_vec++;
      if (ifm_q.size() == 0) begin n_err++; $display("FAIL sb_ifm_extra got %h want none t=%0t", bus.ifm, $time); end
      else begin
        ei = ifm_q.pop_front(); last_ifm = ei;
        if (bus.ifm !== ei) begin n_err++; $display("FAIL sb_ifm got %h want %h t=%0t", bus.ifm, ei, $time); end
      end
    end else begin
      n_vec++;
      if (bus.ifm !== last_ifm) begin n_err++; $display("FAIL sb_ifm_hold got %h want %h t=%0t", bus.ifm, last_ifm, $time); end
    end
    n_vec++;
    if (bus.wgt_valid !== exp_wgt_v) begin n_err++; $display("FAIL sb_wgt_valid got %b want %b t=%0t", bus.wgt_valid, exp_wgt_v, $time); end
    if (bus.wgt_valid === 1'b1) begin
      n_vec++;
      if (wgt_q.size() == 0) begin n_err++; $display("FAIL sb_wgt_extra got %h want none t=%0t", bus.wgt, $time); end
      else begin
        ew = wgt_q.pop_front(); last_wgt = ew;
        if (bus.wgt !== ew) begin n_err++; $display("FAIL sb_wgt got %h want %h t=%0t", bus.wgt, ew, $time); end
      end
    end else begin
      n_vec++;
      if (bus.wgt !== last_wgt) begin n_err++; $display("FAIL sb_wgt_hold got %h want %h t=%0t", bus.wgt, last_wgt, $time); end
    end

    start = st; bus.ifm_read = ir; bus.wgt_read = wr; rst = r;
    cur_state = m_state;
    cur_stall = m_stall;
    if (m_state == S_IFM && ir) m_iaddr = m_ifm_idx;
    if (m_state == S_WGT && wr) m_waddr = m_wgt_lin;
    exp_ifm_v = (m_state == S_IFM) && ir && !r;
    exp_wgt_v = (m_state == S_WGT) && wr && !r;
    if (r) begin
      m_state = S_IDLE; m_ifm_idx = 0; m_wgt_lin = 0; m_stall = 0; m_iaddr = 0; m_waddr = 0;
      last_ifm = '0; last_wgt = '0;
      ifm_q.delete(); wgt_q.delete();
    end else begin
      if (exp_ifm_v) ifm_q.push_back(ifm_mem[m_ifm_idx]);
      if (exp_wgt_v) wgt_q.push_back(wgt_mem[m_wgt_lin]);
      if ((m_state == S_IFM && !ir) || (m_state == S_WGT && !wr)) m_stall++;
      case (m_state)
        S_IDLE: if (st) begin m_state = S_IFM; m_ifm_idx = 0; m_wgt_lin = 0; m_stall = 0; end
        S_IFM:  if (ir) begin if (m_ifm_idx == IFM_SIZE - 1) m_state = S_WGT; m_ifm_idx++; end
        S_WGT:  if (wr) begin if (m_wgt_lin == N_WORDS - 1) m_state = S_DONE; m_wgt_lin++; end
        default: m_state = S_IDLE;
      endcase
    end
    #1;
  endtask

  task automatic finish_run();
    for (int c = 0; c < 60 && m_state != S_IDLE; c++) drive(1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.ifm_read = 1'b0; bus.wgt_read = 1'b0;
    repeat (2) @(posedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rst_busy_done got %b%b want 00", busy, done); end
    n_vec++; if (bus.ifm_addr !== '0 || bus.wgt_addr !== '0) begin n_err++; $display("FAIL rst_addr got %h/%h want 0/0", bus.ifm_addr, bus.wgt_addr); end
    n_vec++; if (bus.ifm_ren !== 1'b0 || bus.wgt_ren !== 1'b0) begin n_err++; $display("FAIL rst_ren got %b%b want 00", bus.ifm_ren, bus.wgt_ren); end
    n_vec++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL rst_stall got %0d want 0", stall_cnt); end
  endtask

  task automatic test_basic_stream();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 40 && m_state != S_IDLE; c++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      if (cur_state == S_IFM) begin
        n_vec++; if (bus.ifm_ren !== 1'b1 || bus.ifm_addr !== IFM_AW'(m_iaddr)) begin n_err++; $display("FAIL basic_ifm_req got %b/%0d want 1/%0d", bus.ifm_ren, bus.ifm_addr, m_iaddr); end
        n_vec++; if (bus.wgt_ren !== 1'b0) begin n_err++; $display("FAIL basic_wgt_ren_in_ifm got %b want 0", bus.wgt_ren); end
      end else if (cur_state == S_WGT) begin
        n_vec++; if (bus.wgt_ren !== 1'b1 || bus.wgt_addr !== WGT_AW'(m_waddr)) begin n_err++; $display("FAIL basic_wgt_req got %b/%0d want 1/%0d", bus.wgt_ren, bus.wgt_addr, m_waddr); end
        n_vec++; if (bus.ifm_ren !== 1'b0) begin n_err++; $display("FAIL basic_ifm_ren_in_wgt got %b want 0", bus.ifm_ren); end
      end
      n_vec++; if (busy !== 1'b1 || done !== (cur_state == S_DONE)) begin n_err++; $display("FAIL basic_busy_done got %b%b want 1%b", busy, done, cur_state == S_DONE); end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL basic_after_done got %b%b want 00", busy, done); end
  endtask

  task automatic test_throttled();
    logic [5:0] ifm_pat;
    ifm_pat = 6'b110101;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, ifm_pat[c], 1'b0, 1'b0);
      n_vec++; if (bus.ifm_ren !== ifm_pat[c] || bus.ifm_addr !== IFM_AW'(m_iaddr)) begin n_err++; $display("FAIL thr_ifm_req c=%0d got %b/%0d want %b/%0d", c, bus.ifm_ren, bus.ifm_addr, ifm_pat[c], m_iaddr); end
    end
    for (int c = 0; c < 40 && m_state != S_IDLE; c++) begin
      drive(1'b0, 1'b0, c[0], 1'b0);
      if (c == 0) begin
        n_vec++; if (stall_cnt !== exp_stall()) begin n_err++; $display("FAIL thr_stall_after_ifm got %0d want %0d", stall_cnt, exp_stall()); end
      end
      if (cur_state == S_WGT) begin
        n_vec++; if (bus.wgt_ren !== c[0] || bus.wgt_addr !== WGT_AW'(m_waddr)) begin n_err++; $display("FAIL thr_wgt_req got %b/%0d want %b/%0d", bus.wgt_ren, bus.wgt_addr, c[0], m_waddr); end
      end
    end
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (stall_cnt !== exp_stall()) begin n_err++; $display("FAIL thr_stall_idle_hold got %0d want %0d", stall_cnt, exp_stall()); end
  endtask

  task automatic test_tile_boundary();
    logic chk;
    logic [WW-1:0] word;
    chk = 1'b0;
    word = wgt_mem[IFM_SIZE];
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 40 && m_state != S_IDLE; c++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      if (chk) begin
        for (int k = 0; k < TILING_SIZE; k++) begin
          n_vec++; if (bus.wgt[k*WGT_WIDTH +: WGT_WIDTH] !== word[k*WGT_WIDTH +: WGT_WIDTH]) begin n_err++; $display("FAIL tile_lane%0d got %h want %h", k, bus.wgt[k*WGT_WIDTH +: WGT_WIDTH], word[k*WGT_WIDTH +: WGT_WIDTH]); end
        end
      end
      chk = (cur_state == S_WGT) && (m_waddr == IFM_SIZE);
      if (chk) begin
        n_vec++; if (bus.wgt_addr !== WGT_AW'(IFM_SIZE)) begin n_err++; $display("FAIL tile_addr got %0d want %0d", bus.wgt_addr, IFM_SIZE); end
      end
    end
  endtask

  task automatic test_ignored_inputs();
    logic st;
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    n_vec++; if (bus.ifm_ren !== 1'b0 || bus.wgt_ren !== 1'b0) begin n_err++; $display("FAIL ign_idle_ren got %b%b want 00", bus.ifm_ren, bus.wgt_ren); end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 40 && m_state != S_IDLE; c++) begin
      st = (m_state == S_IFM && m_ifm_idx == 1) || (m_state == S_WGT && m_wgt_lin == 2) || (m_state == S_DONE);
      drive(st, 1'b1, 1'b1, 1'b0);
      if (cur_state == S_IFM) begin
        n_vec++; if (bus.wgt_ren !== 1'b0) begin n_err++; $display("FAIL ign_wgt_ren_in_ifm got %b want 0", bus.wgt_ren); end
      end else if (cur_state == S_WGT) begin
        n_vec++; if (bus.wgt_addr !== WGT_AW'(m_waddr) || bus.ifm_ren !== 1'b0) begin n_err++; $display("FAIL ign_wgt_seq got %0d/%b want %0d/0", bus.wgt_addr, bus.ifm_ren, m_waddr); end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_no_restart got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_wgt();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 40 && !(m_state == S_WGT && m_wgt_lin == 3); c++) drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy_done got %b%b want 00", busy, done); end
    n_vec++; if (bus.valid_ifm !== 1'b0 || bus.wgt_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valids got %b%b want 00", bus.valid_ifm, bus.wgt_valid); end
    n_vec++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL mid_rst_stall got %0d want 0", stall_cnt); end
    n_vec++; if (bus.wgt_addr !== '0) begin n_err++; $display("FAIL mid_rst_wgt_addr got %0d want 0", bus.wgt_addr); end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    n_vec++; if (bus.ifm_ren !== 1'b1 || bus.ifm_addr !== '0) begin n_err++; $display("FAIL mid_rst_replay got %b/%0d want 1/0", bus.ifm_ren, bus.ifm_addr); end
    finish_run();
  endtask

  task automatic test_back_to_back();
    int n_issue;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int run = 0; run < 2; run++) begin
      n_issue = 0;
      for (int c = 0; c < 40 && cur_state != S_DONE; c++) begin
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        if (cur_state == S_WGT) begin
          n_vec++; if (bus.wgt_addr !== WGT_AW'(n_issue)) begin n_err++; $display("FAIL b2b_run%0d_addr got %0d want %0d", run, bus.wgt_addr, n_issue); end
          n_issue++;
        end
      end
      n_vec++; if (done !== 1'b1 || n_issue != N_WORDS) begin n_err++; $display("FAIL b2b_run%0d_done got done=%b words=%0d want 1/%0d", run, done, n_issue, N_WORDS); end
      if (run == 0) drive(1'b1, 1'b0, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_end_busy got %b want 0", busy); end
    n_vec++; if (ifm_q.size() != 0 || wgt_q.size() != 0) begin n_err++; $display("FAIL sb_leftover got %0d/%0d want 0/0", ifm_q.size(), wgt_q.size()); end
  endtask

  initial begin
    bus.ifm_read = 1'b0;
    bus.wgt_read = 1'b0;
    for (int i = 0; i < IFM_SIZE; i++) ifm_mem[i] = IFM_WIDTH'($urandom_range(1, 255));
    for (int i = 0; i < N_WORDS; i++) wgt_mem[i] = {$urandom, $urandom};
    test_reset();
    test_basic_stream();
    test_throttled();
    test_tile_boundary();
    test_ignored_inputs();
    test_reset_mid_wgt();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
